channel_readout_arbiter: RTL
============================

Name: channel_readout_arbiter

Overview:
Round-robin arbiter that shares the single event FIFO write port among all 64 per-channel controllers in digital_core. Each channel raises a request when it holds a completed ADC event. The arbiter grants one channel at a time, tags the event with the channel ID, writes it to the shared FIFO and acknowledges the channel. It sits between the per-channel controllers (fed by analog_core hit/done/dout) and the FIFO that feeds the PISO UARTs.

Parameters:
NUMCHANNELS, 64, number of requesting channels
WIDTH, 64, FIFO word width
CHANNEL_ID_W, 6, channel ID field width; equals $clog2(NUMCHANNELS)
EVENT_W, 58, per-channel event payload width; equals WIDTH-CHANNEL_ID_W

Ports:
clk  input  1  master clock
reset_n  input  1  asynchronous digital reset, active low
arb_enable  input  1  high to allow new grants
req  input  NUMCHANNELS  per-channel event-ready; held high until ack
event_data  input  EVENT_W*NUMCHANNELS  flat payloads; channel k at [k*EVENT_W +: EVENT_W]; stable while req[k]=1
fifo_full  input  1  shared FIFO cannot accept a write
ack  output  NUMCHANNELS  one-hot, single-cycle grant acknowledge
fifo_wr_en  output  1  FIFO write strobe
fifo_wr_data  output  WIDTH  {channel_id, payload}; channel ID in the MSBs
busy  output  1  high in any state except IDLE

Behaviour:
- One clock domain. Reset is asynchronous and active-low; the clock and reset ports are named clk and reset_n.
- Reset values:
  - ack=0, fifo_wr_en=0, fifo_wr_data=0, busy=0.
  - State=IDLE, round-robin pointer ptr=0.
- All outputs are registered.
- IDLE:
  - Evaluate each cycle.
  - If arb_enable=1, fifo_full=0 and |req=1, select winner w = first k with req[k]=1, searching ptr, ptr+1, ..., NUMCHANNELS-1, 0, ..., ptr-1.
  - Latch w and event_data for w. Go to WRITE.
  - If fifo_full=1 and |req=1, go to STALL.
  - Otherwise stay in IDLE.
- WRITE (exactly one cycle):
  - fifo_wr_en=1, fifo_wr_data={w[CHANNEL_ID_W-1:0], latched payload}, ack[w]=1.
  - ptr <= (w+1) mod NUMCHANNELS, wrapping from 63 to 0.
  - Next state IDLE.
- STALL:
  - No grants, all outputs inactive except busy=1.
  - Return to IDLE on the first cycle fifo_full=0.
  - ptr is unchanged.
- Throughput and latency:
  - One event per 2 cycles.
  - Latency from req sampled in IDLE to fifo_wr_en/ack is 1 cycle.
- Handshake:
  - A channel deasserts req on the edge after it sees ack.
  - The arbiter never re-samples req during WRITE, so a stale req cannot be double-granted.
- fifo_full asserting during WRITE does not cancel the write. The FIFO guarantees one slot of margin (full is asserted while one slot is still free).
- arb_enable deasserted during WRITE: the write completes, then the arbiter stays in IDLE.
- A req that drops without ack in IDLE is simply not granted; it is a protocol violation, but no lockup results.
- Simultaneous requests from all channels: grants occur in strict rotation from ptr. Worst-case wait is 2*NUMCHANNELS cycles with the FIFO never full.
- reset_n asserted mid-operation: immediate return to the reset state. An in-flight write is dropped (fifo_wr_en clears asynchronously).

Optional Feature:
- Macro: ARB_EVENT_COUNTER_EN.
- With the macro defined:
  - Add outputs event_count[15:0] and stall_count[15:0], both saturating at 16'hFFFF and reset to 0.
  - event_count increments on every WRITE cycle.
  - stall_count increments on every cycle spent in STALL.
  - Add input count_clear (1 bit): synchronously zeroes both counters.
  - If count_clear and an increment coincide, the clear wins.
- Without the macro: these ports and registers are absent, and all other behaviour is identical.

Decomposition:
- Package larpix_arb_pkg:
  - typedef enum logic [1:0] {IDLE, WRITE, STALL} arb_state_t.
  - Localparams CHANNEL_ID_W and EVENT_W derived from NUMCHANNELS=64 and WIDTH=64.
  - Counter width constant 16.
- One sub-module: rr_priority_encoder.
  - Combinational find-first-set starting at ptr, built by rotate, priority-encode, then un-rotate.
  - Outputs winner index and valid.
  - Parameterized by NUMCHANNELS.

Test Plan:
- Single request: req[5]=1, payload 58'h1234 → 1 cycle later fifo_wr_en=1, fifo_wr_data={6'd5,58'h1234}, ack=64'h20 for one cycle, busy=1. Next cycle busy=0, ptr=6.
- Round-robin fairness: all 64 req held high, each channel dropping req after its ack → 64 writes with channel IDs 0,1,...,63 in order, one every 2 cycles. ptr wraps 63→0.
- Pointer rotation: ptr=10, req[3] and req[40] high → channel 40 granted first, then channel 3.
- Backpressure: fifo_full=1 with req[7]=1 → state STALL, no fifo_wr_en and no ack for 20 cycles. fifo_full drops → channel 7 written within 2 cycles.
- Reset mid-WRITE: assert reset_n=0 during the WRITE cycle → fifo_wr_en and ack go to 0 immediately. After release, state=IDLE and ptr=0.
- ARB_EVENT_COUNTER_EN: 70000 grants → event_count=16'hFFFF (saturated). count_clear pulse → both counters 0. 5 stall cycles → stall_count=5.

Source files
------------

// File: rtl/larpix_arb_pkg.sv
// Shared types and constants for the channel readout arbiter.
// Build option: ARB_EVENT_COUNTER_EN adds event/stall counters.
package larpix_arb_pkg;

   localparam int NUMCHANNELS  = 64;
   localparam int WIDTH        = 64;
   localparam int CHANNEL_ID_W = $clog2(NUMCHANNELS);
   localparam int EVENT_W      = WIDTH - CHANNEL_ID_W;
   localparam int CNT_W        = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      STALL = 2'd2
   } arb_state_t;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/channel_readout_arbiter_rr_priority_encoder.sv
// Round-robin find-first-set: rotate by ptr, priority-encode,
// then un-rotate the index back into channel numbering.
module rr_priority_encoder #(
   parameter int NUMCHANNELS = 64
) (
   input  logic [NUMCHANNELS-1:0]         req,
   input  logic [$clog2(NUMCHANNELS)-1:0] ptr,
   output logic [$clog2(NUMCHANNELS)-1:0] winner,
   output logic                           valid
);

   localparam int IW = $clog2(NUMCHANNELS);

   logic [NUMCHANNELS-1:0] rot;
   logic [IW-1:0]          idx;
   logic [IW:0]            sum;
   logic [IW:0]            diff;

   // rot[i] is the channel i places after ptr
   always_comb begin
      rot = '0;
      for (int i = 0; i < NUMCHANNELS; i++) begin
         int j;
         j = i + int'(ptr);
         if (j >= NUMCHANNELS) j = j - NUMCHANNELS;
         rot[i] = req[j];
      end
   end

   // lowest set bit of the rotated vector is the nearest requester
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = NUMCHANNELS - 1; i >= 0; i--) begin
         if (rot[i]) begin
            idx   = IW'(i);
            valid = 1'b1;
         end
      end
   end

   // undo the rotation modulo NUMCHANNELS
   always_comb begin
      sum  = {1'b0, idx} + {1'b0, ptr};
      diff = sum - (IW+1)'(NUMCHANNELS);
      if (sum >= (IW+1)'(NUMCHANNELS))
         winner = diff[IW-1:0];
      else
         winner = sum[IW-1:0];
   end

endmodule

// File: rtl/channel_readout_arbiter.sv
// Shares the event FIFO write port among all channel controllers.
// Build option: ARB_EVENT_COUNTER_EN adds event/stall counters.
module channel_readout_arbiter
   import larpix_arb_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           arb_enable,
   input  logic [NUMCHANNELS-1:0]         req,
   input  logic [EVENT_W*NUMCHANNELS-1:0] event_data,
   input  logic                           fifo_full,
`ifdef ARB_EVENT_COUNTER_EN
   input  logic                           count_clear,
   output logic [CNT_W-1:0]               event_count,
   output logic [CNT_W-1:0]               stall_count,
`endif
   output logic [NUMCHANNELS-1:0]         ack,
   output logic                           fifo_wr_en,
   output logic [WIDTH-1:0]               fifo_wr_data,
   output logic                           busy
);

   arb_state_t              state_q;
   arb_state_t              state_d;
   logic [CHANNEL_ID_W-1:0] ptr_q;
   logic [CHANNEL_ID_W-1:0] win_q;
   logic [CHANNEL_ID_W-1:0] enc_win;
   logic                    enc_valid;
   logic                    grant;
   logic [EVENT_W-1:0]      payload;

   rr_priority_encoder #(
      .NUMCHANNELS (NUMCHANNELS)
   ) u_enc (
      .req    (req),
      .ptr    (ptr_q),
      .winner (enc_win),
      .valid  (enc_valid)
   );

   assign payload = event_data[enc_win*EVENT_W +: EVENT_W];

   // next state; req is only looked at while idle
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arb_enable && !fifo_full && enc_valid) begin
               state_d = WRITE;
               grant   = 1'b1;
            end else if (fifo_full && enc_valid) begin
               state_d = STALL;
            end
         end
         WRITE: state_d = IDLE;
         STALL: if (!fifo_full) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state, pointer and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         win_q        <= '0;
         ack          <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
         busy         <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy       <= (state_d != IDLE);
         fifo_wr_en <= grant;
         if (grant) begin
            win_q        <= enc_win;
            ack          <= NUMCHANNELS'(1) << enc_win;
            fifo_wr_data <= {enc_win, payload};
         end else begin
            ack          <= '0;
            fifo_wr_data <= '0;
         end
         if (state_q == WRITE) begin
            if (win_q == CHANNEL_ID_W'(NUMCHANNELS - 1))
               ptr_q <= '0;
            else
               ptr_q <= win_q + 1'b1;
         end
      end
   end

`ifdef ARB_EVENT_COUNTER_EN
   // saturating activity counters; clear beats increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         event_count <= '0;
         stall_count <= '0;
      end else if (count_clear) begin
         event_count <= '0;
         stall_count <= '0;
      end else begin
         if (state_q == WRITE) event_count <= sat_inc(event_count);
         if (state_q == STALL) stall_count <= sat_inc(stall_count);
      end
   end
`endif

endmodule
